hand_sensor_decoder: RTL

- Front-end that produces the 2-bit `hand` code consumed by the LED/audio gesture FSM.
- Fires two HC-SR04-style ultrasonic sensors together and times their echo pulses in microseconds.
- Thresholds each channel to near/far and debounces the result over consecutive measurements.
- Presents a stable `hand[1:0]` to the gesture FSM: bit0 = sensor 0 near, bit1 = sensor 1 near; 2'b11 = both, 2'b01 = sensor 0 only.

---
 rtl/hand_pkg.sv | 32 +++
 rtl/echo_timer.sv | 103 ++++++++++
 rtl/hand_sensor_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hand_pkg.sv
// hand_pkg: shared hand codes, FSM state encodings and counter widths for
// the hand sensor decoder and its echo timers.
package hand_pkg;

  localparam int US_W     = 15;
  localparam int PERIOD_W = 16;

  localparam logic [US_W-1:0] US_MAX = '1;

  localparam logic [1:0] HAND_NONE = 2'b00;
  localparam logic [1:0] HAND_S0   = 2'b01;
  localparam logic [1:0] HAND_BOTH = 2'b11;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_TRIG   = 2'd1,
    M_LISTEN = 2'd2,
    M_DONE   = 2'd3
  } master_state_t;

  typedef enum logic [1:0] {
    C_WAIT_RISE = 2'd0,
    C_HIGH      = 2'd1,
    C_FIN       = 2'd2
  } chan_state_t;

  // Width counters stick at all-ones instead of wrapping back to a near value.
  function automatic logic [US_W-1:0] sat_inc(input logic [US_W-1:0] v);
    return (v == US_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/echo_timer.sv
// echo_timer: one ultrasonic channel. Synchronizes the raw echo line, waits
// for a rising edge while the master is listening, times the echo pulse in
// microseconds and holds a near/far verdict until the master's DONE state.
// With HAND_DIST_OUT_EN defined the measured width is exported as a port.
module echo_timer
  import hand_pkg::*;
#(
  parameter int TIMEOUT_US = 25_000,
  parameter int NEAR_US    = 1_200
) (
  input  logic clk,
  input  logic reset,
  input  logic us_tick,
  input  logic echo,
  input  logic run,
  input  logic done,
  output logic fin,
  output logic near
`ifdef HAND_DIST_OUT_EN
  ,
  output logic [US_W-1:0] width
`endif
);

`ifndef HAND_DIST_OUT_EN
  logic [US_W-1:0] width;
`endif

  localparam logic [US_W-1:0] TIMEOUT_W = US_W'(TIMEOUT_US);
  localparam logic [US_W-1:0] NEAR_W    = US_W'(NEAR_US);

  logic            echo_p0, echo_p1, echo_p2;
  logic            rise;
  logic            result;
  logic [US_W-1:0] wait_cnt;
  logic [US_W-1:0] width_inc;
  chan_state_t     state;

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    echo_p0 <= echo;
    echo_p1 <= echo_p0;
    echo_p2 <= echo_p1;
  end

  // An echo already high when listening starts shows no edge here, so it is
  // ignored until it falls and rises again.
  assign rise      = echo_p1 & ~echo_p2;
  assign width_inc = sat_inc(width);
  assign fin       = (state == C_FIN);
  assign near      = fin & result;

  // Channel FSM: wait for rise, time the pulse, hold the verdict
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= C_WAIT_RISE;
      wait_cnt <= '0;
      width    <= '0;
      result   <= 1'b0;
    end else if (done) begin
      state    <= C_WAIT_RISE;
      wait_cnt <= '0;
    end else begin
      case (state)
        C_WAIT_RISE: begin
          if (run) begin
            if (rise) begin
              // The tick coinciding with the rise counts, so a pulse of
              // N microseconds synchronous to clk measures exactly N.
              state <= C_HIGH;
              width <= US_W'(us_tick);
            end else if (us_tick) begin
              if (wait_cnt == TIMEOUT_W - 1'b1) begin
                state  <= C_FIN;
                result <= 1'b0;
                width  <= US_MAX;
              end else begin
                wait_cnt <= wait_cnt + 1'b1;
              end
            end
          end
        end
        C_HIGH: begin
          if (!echo_p1) begin
            state  <= C_FIN;
            result <= (width < NEAR_W);
          end else if (us_tick) begin
            width <= width_inc;
            if (width_inc >= TIMEOUT_W) begin
              state  <= C_FIN;
              result <= 1'b0;
            end
          end
        end
        C_FIN: begin
          state <= C_FIN;
        end
        default: state <= C_WAIT_RISE;
      endcase
    end
  end

endmodule

// File: rtl/hand_sensor_decoder.sv
// hand_sensor_decoder: fires two ultrasonic sensors each measurement cycle,
// classifies each echo as near/far and debounces the result into hand[1:0]
// (bit0 = sensor 0 near, bit1 = sensor 1 near).
// Optional macro HAND_DIST_OUT_EN adds dist0/dist1 outputs carrying the last
// measured echo widths in microseconds.
module hand_sensor_decoder
  import hand_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60_000,
  parameter int TIMEOUT_US = 25_000,
  parameter int NEAR_US    = 1_200,
  parameter int STABLE_N   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] echo,
  output logic [1:0] trig,
  output logic [1:0] hand,
  output logic       valid
`ifdef HAND_DIST_OUT_EN
  ,
  output logic [14:0] dist0,
  output logic [14:0] dist1
`endif
);

  localparam int DIV   = CLK_HZ / 1_000_000;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST    = PRE_W'(DIV - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD_US - 1);
  localparam logic [PERIOD_W-1:0] TRIG_LAST   = PERIOD_W'(TRIG_US - 1);
  localparam logic [PERIOD_W-1:0] LISTEN_LAST = PERIOD_W'(2 * TIMEOUT_US - 1);
  localparam logic [1:0]          STABLE_C    = 2'(STABLE_N);

  logic [PRE_W-1:0]    pre_cnt;
  logic                us_tick;
  logic [PERIOD_W-1:0] cyc_cnt;
  logic                cyc_start;
  logic [PERIOD_W-1:0] step_cnt;
  master_state_t       mstate;
  logic                run, done;
  logic                fin0, fin1, near0, near1;
  logic [1:0]          agree0, agree1;

  // Returns {new hand bit, new agree count} for one measurement.
  function automatic logic [2:0] debounce(input logic cur, input logic meas,
                                          input logic [1:0] cnt);
    logic [1:0] nxt;
    if (meas == cur) return {cur, 2'b00};
    nxt = cnt + 2'd1;
    if (nxt == STABLE_C) return {~cur, 2'b00};
    return {cur, nxt};
  endfunction

  // Microsecond prescaler: one-clk tick every DIV clocks
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt <= '0;
      us_tick <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      us_tick <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      us_tick <= 1'b0;
    end
  end

  // Free-running measurement cycle timer, independent of echo behaviour
  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_cnt <= '0;
    end else if (us_tick) begin
      cyc_cnt <= (cyc_cnt == PERIOD_LAST) ? '0 : cyc_cnt + 1'b1;
    end
  end

  // The tick at cycle position 0 starts a measurement; after reset this is
  // the very first tick.
  assign cyc_start = us_tick && (cyc_cnt == '0);
  assign run       = (mstate == M_LISTEN);
  assign done      = (mstate == M_DONE);

  // Master FSM: trigger, listen, then publish one result per cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      mstate   <= M_IDLE;
      trig     <= 2'b00;
      valid    <= 1'b0;
      step_cnt <= '0;
    end else begin
      valid <= 1'b0;
      case (mstate)
        M_IDLE: begin
          if (cyc_start) begin
            mstate   <= M_TRIG;
            trig     <= 2'b11;
            step_cnt <= '0;
          end
        end
        M_TRIG: begin
          if (us_tick) begin
            if (step_cnt == TRIG_LAST) begin
              mstate   <= M_LISTEN;
              trig     <= 2'b00;
              step_cnt <= '0;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        M_LISTEN: begin
          if (fin0 && fin1) begin
            mstate <= M_DONE;
          end else if (us_tick) begin
            if (step_cnt == LISTEN_LAST) begin
              mstate <= M_DONE;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        M_DONE: begin
          valid  <= 1'b1;
          mstate <= M_IDLE;
        end
        default: mstate <= M_IDLE;
      endcase
    end
  end

  // Debouncers: a channel that never finished counts as far
  always_ff @(posedge clk) begin
    if (!reset) begin
      hand   <= HAND_NONE;
      agree0 <= 2'b00;
      agree1 <= 2'b00;
    end else if (done) begin
      {hand[0], agree0} <= debounce(hand[0], near0, agree0);
      {hand[1], agree1} <= debounce(hand[1], near1, agree1);
    end
  end

`ifdef HAND_DIST_OUT_EN
  logic [US_W-1:0] width0, width1;

  echo_timer #(.TIMEOUT_US(TIMEOUT_US), .NEAR_US(NEAR_US)) u_ch0 (
    .clk(clk), .reset(reset), .us_tick(us_tick), .echo(echo[0]),
    .run(run), .done(done), .fin(fin0), .near(near0), .width(width0)
  );

  echo_timer #(.TIMEOUT_US(TIMEOUT_US), .NEAR_US(NEAR_US)) u_ch1 (
    .clk(clk), .reset(reset), .us_tick(us_tick), .echo(echo[1]),
    .run(run), .done(done), .fin(fin1), .near(near1), .width(width1)
  );

  // Distance outputs follow the same cadence as valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      dist0 <= '0;
      dist1 <= '0;
    end else if (done) begin
      dist0 <= width0;
      dist1 <= width1;
    end
  end
`else
  echo_timer #(.TIMEOUT_US(TIMEOUT_US), .NEAR_US(NEAR_US)) u_ch0 (
    .clk(clk), .reset(reset), .us_tick(us_tick), .echo(echo[0]),
    .run(run), .done(done), .fin(fin0), .near(near0)
  );

  echo_timer #(.TIMEOUT_US(TIMEOUT_US), .NEAR_US(NEAR_US)) u_ch1 (
    .clk(clk), .reset(reset), .us_tick(us_tick), .echo(echo[1]),
    .run(run), .done(done), .fin(fin1), .near(near1)
  );
`endif

endmodule
